// File: rtl/int_pkg.sv
// Shared definitions for the three-level nested interrupt controller:
// level encodings, FSM state type, default handler entries and priority encoder.
package int_pkg;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL1     = 2'd1;
  localparam logic [1:0] LVL2     = 2'd2;
  localparam logic [1:0] LVL3     = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_HANDLER1_ADDR = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER2_ADDR = 32'h0000_3100;
  localparam logic [31:0] DEF_HANDLER3_ADDR = 32'h0000_3200;

  // Highest set bit of a level vector (bit i-1 = level i), LVL_NONE if empty.
  function automatic logic [1:0] prio_enc(input logic [2:0] vec);
    if (vec[2])      return LVL3;
    else if (vec[1]) return LVL2;
    else if (vec[0]) return LVL1;
    else             return LVL_NONE;
  endfunction

  function automatic logic [2:0] lvl_onehot(input logic [1:0] lvl);
    case (lvl)
      LVL1:    return 3'b001;
      LVL2:    return 3'b010;
      LVL3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector;
// o_pulse is high for exactly one clock per rising edge of i_d.
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_d,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/int_ctrl.sv
// Three-level nested priority interrupt controller (3 > 2 > 1) with req/ack handshake.
// Optional per-level ack counters cnt1..cnt3 are built when INT_CTRL_COUNT_EN is defined.
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] HANDLER1_ADDR = DEF_HANDLER1_ADDR,
  parameter logic [31:0] HANDLER2_ADDR = DEF_HANDLER2_ADDR,
  parameter logic [31:0] HANDLER3_ADDR = DEF_HANDLER3_ADDR,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [2:0]  inter,
  input  logic        ie,
  input  logic        int_ack,
  input  logic        eret,
  output logic        int_req,
  output logic [1:0]  int_level,
  output logic [31:0] handler_addr,
  output logic [2:0]  inter_running,
  output logic [1:0]  dbg_state
`ifdef INT_CTRL_COUNT_EN
  ,
  output logic [31:0] cnt1,
  output logic [31:0] cnt2,
  output logic [31:0] cnt3
`endif
);

  // Handshake: int_req stays high with a stable int_level/handler_addr (except for
  // re-prioritisation to a higher level) until the core pulses int_ack; dropping ie
  // withdraws the request without losing the pending bit.
  logic [2:0] w_edge;
  logic [2:0] r_pending;
  logic [2:0] r_in_service;
  logic [1:0] r_req_level;
  state_e     r_state;
  state_e     w_next_state;
  logic [1:0] w_cur_level;
  logic [2:0] w_above;
  logic [1:0] w_cand;
  logic [2:0] w_eret_clr;
  logic [2:0] w_ack_set;

  for (genvar g = 0; g < 3; g++) begin : g_sync
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_d     (inter[g]),
      .o_pulse (w_edge[g])
    );
  end

  assign w_cur_level = prio_enc(r_in_service);
  assign w_above     = 3'b111 << w_cur_level;
  assign w_cand      = prio_enc(r_pending & w_above);
  assign w_eret_clr  = eret ? lvl_onehot(w_cur_level) : 3'b000;
  assign w_ack_set   = (r_state == ACK) ? lvl_onehot(r_req_level) : 3'b000;

  // New edges are OR-ed in after the ack clear so a same-cycle edge survives.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pending    <= 3'b000;
      r_in_service <= 3'b000;
    end else begin
      r_pending    <= (r_pending & ~w_ack_set) | w_edge;
      r_in_service <= (r_in_service & ~w_eret_clr) | w_ack_set;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (ie && (w_cand != LVL_NONE) && !eret) w_next_state = REQ;
      REQ: begin
        if (!ie)          w_next_state = IDLE;
        else if (int_ack) w_next_state = ACK;
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_req_level <= LVL_NONE;
    end else if (r_state == IDLE && w_next_state == REQ) begin
      r_req_level <= w_cand;
    end else if (r_state == REQ && w_next_state == REQ && w_cand > r_req_level) begin
      r_req_level <= w_cand;
    end
  end

  always_comb begin
    int_req      = 1'b0;
    int_level    = LVL_NONE;
    handler_addr = 32'h0;
    if (r_state == REQ) begin
      int_req   = 1'b1;
      int_level = r_req_level;
      case (r_req_level)
        LVL1:    handler_addr = HANDLER1_ADDR;
        LVL2:    handler_addr = HANDLER2_ADDR;
        LVL3:    handler_addr = HANDLER3_ADDR;
        default: handler_addr = 32'h0;
      endcase
    end
  end

  assign inter_running = r_in_service;
  assign dbg_state     = r_state;

`ifdef INT_CTRL_COUNT_EN
  logic [31:0] r_cnt1;
  logic [31:0] r_cnt2;
  logic [31:0] r_cnt3;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt1 <= 32'h0;
      r_cnt2 <= 32'h0;
      r_cnt3 <= 32'h0;
    end else begin
      if (w_ack_set[0]) r_cnt1 <= r_cnt1 + 32'd1;
      if (w_ack_set[1]) r_cnt2 <= r_cnt2 + 32'd1;
      if (w_ack_set[2]) r_cnt3 <= r_cnt3 + 32'd1;
    end
  end

  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;
  assign cnt3 = r_cnt3;
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus randomized request bursts for int_ctrl, checked against
// a transaction-level model of pending / in-service levels.
module tb_int_ctrl;

  logic        clk;
  logic        clr_n;
  logic [2:0]  inter;
  logic        ie;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [1:0]  int_level;
  logic [31:0] handler_addr;
  logic [2:0]  inter_running;
  logic [1:0]  dbg_state;
`ifdef INT_CTRL_COUNT_EN
  logic [31:0] cnt1;
  logic [31:0] cnt2;
  logic [31:0] cnt3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending and in-service sets, per-level ack counts.
  logic [2:0] m_pend;
  logic [2:0] m_serv;
  int         m_cnt [1:3];

  int_ctrl dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .inter         (inter),
    .ie            (ie),
    .int_ack       (int_ack),
    .eret          (eret),
    .int_req       (int_req),
    .int_level     (int_level),
    .handler_addr  (handler_addr),
    .inter_running (inter_running),
    .dbg_state     (dbg_state)
`ifdef INT_CTRL_COUNT_EN
    ,
    .cnt1          (cnt1),
    .cnt2          (cnt2),
    .cnt3          (cnt3)
`endif
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int lvl);
    return 32'h0000_3000 + 32'(lvl - 1) * 32'h100;
  endfunction

  function automatic int top_level(input logic [2:0] set);
    int t = 0;
    for (int l = 1; l <= 3; l++) if (set[l-1]) t = l;
    return t;
  endfunction

  function automatic int model_cand();
    int c = 0;
    for (int l = top_level(m_serv) + 1; l <= 3; l++) if (m_pend[l-1]) c = l;
    return c;
  endfunction

  task automatic model_reset();
    m_pend = 3'b000;
    m_serv = 3'b000;
    for (int l = 1; l <= 3; l++) m_cnt[l] = 0;
  endtask

  // Driver tasks
  task automatic pulse(input logic [2:0] mask);
    inter = mask;
    tick();
    inter = 3'b000;
    m_pend = m_pend | mask;
  endtask

  task automatic do_ack(input int lvl);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
    m_pend[lvl-1] = 1'b0;
    m_serv[lvl-1] = 1'b1;
    m_cnt[lvl]++;
  endtask

  task automatic do_eret();
    int t;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    t = top_level(m_serv);
    if (t != 0) m_serv[t-1] = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int lvl, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (int_req) break;
      tick();
    end
    check({tag, "_req"}, 32'(int_req), 32'd1);
    check({tag, "_lvl"}, 32'(int_level), 32'(lvl));
    check({tag, "_addr"}, handler_addr, exp_addr(lvl));
  endtask

  task automatic watch_no_req(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | int_req;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0] sub;
    logic [2:0] one;
    int         c;
    int         guard;

    clr_n = 1'b0; inter = 3'b000; ie = 1'b0; int_ack = 1'b0; eret = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_req", 32'(int_req), 32'd0);
    check("rst_lvl", 32'(int_level), 32'd0);
    check("rst_addr", handler_addr, 32'd0);
    check("rst_run", 32'(inter_running), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    clr_n = 1'b1;
    tick();
    ie = 1'b1;

    // Single request and exact latency
    pulse(3'b001);
    repeat (3) tick();
    check("lat_early", 32'(int_req), 32'd0);
    tick();
    check("lat_req", 32'(int_req), 32'd1);
    check("lat_lvl", 32'(int_level), 32'd1);
    check("lat_addr", handler_addr, 32'h0000_3000);
    do_ack(1);
    check("single_run", 32'(inter_running), 32'b001);
    do_eret();
    check("single_pop", 32'(inter_running), 32'b000);

    // Nested preemption 1 -> 2 -> 3 and unwind
    pulse(3'b001); wait_req("pre1", 1, 12); do_ack(1);
    check("pre1_run", 32'(inter_running), 32'b001);
    pulse(3'b010); wait_req("pre2", 2, 12); do_ack(2);
    check("pre2_run", 32'(inter_running), 32'b011);
    pulse(3'b100); wait_req("pre3", 3, 12); do_ack(3);
    check("pre3_run", 32'(inter_running), 32'b111);
    do_eret(); check("pop3", 32'(inter_running), 32'b011);
    do_eret(); check("pop2", 32'(inter_running), 32'b001);
    do_eret(); check("pop1", 32'(inter_running), 32'b000);

    // Lower level held off while a higher one is in service
    pulse(3'b100); wait_req("hi", 3, 12); do_ack(3);
    pulse(3'b001);
    watch_no_req("low_blocked", 8);
    do_eret();
    wait_req("low_after", 1, 2);
    do_ack(1); do_eret();
    check("low_done", 32'(inter_running), 32'b000);

    // Re-prioritise an un-acked request
    pulse(3'b001); wait_req("rp1", 1, 12);
    pulse(3'b100);
    for (int i = 0; i < 8; i++) begin
      if (int_level == 2'd3) break;
      tick();
    end
    check("rp_req", 32'(int_req), 32'd1);
    check("rp_lvl", 32'(int_level), 32'd3);
    check("rp_addr", handler_addr, 32'h0000_3200);
    do_ack(3);
    check("rp_run", 32'(inter_running), 32'b100);
    do_eret();
    wait_req("rp_left", 1, 4);
    do_ack(1); do_eret();

    // Repeated edges on one level merge into a single request
    pulse(3'b010); tick(); pulse(3'b010);
    wait_req("merge", 2, 12);
    repeat (4) tick();
    do_ack(2); do_eret();
    watch_no_req("merge_once", 8);

    // Masking, then asynchronous reset in the middle of a request
    pulse(3'b001); wait_req("mk1", 1, 12); do_ack(1);
    ie = 1'b0;
    pulse(3'b010);
    watch_no_req("masked", 8);
    ie = 1'b1;
    wait_req("unmask", 2, 3);
    #2 clr_n = 1'b0;
    #1;
    check("arst_req", 32'(int_req), 32'd0);
    check("arst_lvl", 32'(int_level), 32'd0);
    check("arst_addr", handler_addr, 32'd0);
    check("arst_run", 32'(inter_running), 32'd0);
    model_reset();
    tick();
    clr_n = 1'b1;
    watch_no_req("post_rst", 6);

    // Counter scenario: two level-2 acks and one level-3 ack since reset
    pulse(3'b010); wait_req("c2a", 2, 12); do_ack(2); do_eret();
    pulse(3'b010); wait_req("c2b", 2, 12); do_ack(2); do_eret();
    pulse(3'b100); wait_req("c3", 3, 12); do_ack(3); do_eret();
`ifdef INT_CTRL_COUNT_EN
    check("cnt1", cnt1, 32'd0);
    check("cnt2", cnt2, 32'd2);
    check("cnt3", cnt3, 32'd1);
`endif

    // Randomized bursts served by a model-driven core
    for (int r = 0; r < 20; r++) begin
      sub = 3'($urandom_range(1, 7));
      for (int b = 0; b < 3; b++) begin
        if (sub[b]) begin
          one = 3'b001 << b;
          pulse(one);
          if ($urandom_range(0, 3) == 0) begin
            tick();
            pulse(one);
          end
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      repeat (8) tick();
      guard = 0;
      while ((m_pend != 3'b000 || m_serv != 3'b000) && guard < 12) begin
        guard++;
        c = model_cand();
        if (c != 0) begin
          wait_req("rnd", c, 12);
          do_ack(c);
          check("rnd_run", 32'(inter_running), 32'(m_serv));
        end else begin
          do_eret();
          check("rnd_pop", 32'(inter_running), 32'(m_serv));
        end
      end
      check("rnd_drain", 32'(guard < 12), 32'd1);
      watch_no_req("rnd_idle", 4);
    end
`ifdef INT_CTRL_COUNT_EN
    check("cnt1_end", cnt1, 32'(m_cnt[1]));
    check("cnt2_end", cnt2, 32'(m_cnt[2]));
    check("cnt3_end", cnt3, 32'(m_cnt[3]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
